// File: rtl/rom_burst_reader.sv
// Burst read initiator for a small synchronous ROM: sweeps consecutive addresses with wrap
// and presents each captured word on a valid/ready stream tagged with address and last flag.
module rom_burst_reader #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN_W  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [LEN_W-1:0]  burst_len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              rom_en_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [ADDR_W-1:0] out_addr_o,
   output logic              out_last_o
);

   localparam int unsigned      Depth  = 2 ** ADDR_W;
   localparam logic [LEN_W-1:0] MaxLen = LEN_W'(Depth);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

   state_e            state_q;
   logic              busy_q;
   logic              done_q;
   logic              rom_en_q;
   logic [ADDR_W-1:0] rom_addr_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic              out_last_q;
   logic [ADDR_W-1:0] cur_addr_q;
   logic [LEN_W-1:0]  remaining_q;

   logic [LEN_W-1:0]  len_clamped;
   logic [ADDR_W-1:0] next_addr;

   // Requests longer than the ROM depth read every location exactly once.
   assign len_clamped = (burst_len_i > MaxLen) ? MaxLen : burst_len_i;
   assign next_addr   = cur_addr_q + ADDR_W'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rom_en_q    <= 1'b0;
         rom_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_last_q  <= 1'b0;
         cur_addr_q  <= '0;
         remaining_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  if (burst_len_i == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     cur_addr_q  <= start_addr_i;
                     remaining_q <= len_clamped;
                     rom_addr_q  <= start_addr_i;
                     rom_en_q    <= 1'b1;
                     busy_q      <= 1'b1;
                     state_q     <= StReq;
                  end
               end
            end
            StReq: begin
               rom_en_q <= 1'b0;
               state_q  <= StWait;
            end
            StWait: begin
               out_data_q  <= rom_data_i;
               out_addr_q  <= cur_addr_q;
               out_last_q  <= (remaining_q == LEN_W'(1));
               out_valid_q <= 1'b1;
               state_q     <= StHold;
            end
            StHold: begin
               // out_valid is always high here, so ready alone completes the handshake.
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  remaining_q <= remaining_q - LEN_W'(1);
                  if (out_last_q) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= StIdle;
                  end else begin
                     cur_addr_q <= next_addr;
                     rom_addr_q <= next_addr;
                     rom_en_q   <= 1'b1;
                     state_q    <= StReq;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign rom_en_o    = rom_en_q;
   assign rom_addr_o  = rom_addr_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_addr_o  = out_addr_q;
   assign out_last_o  = out_last_q;

   a_rom_en_single : assert property (@(posedge clk_i) disable iff (rst_i)
      rom_en_o |=> !rom_en_o);

   a_out_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_data_o)
                                         && $stable(out_addr_o) && $stable(out_last_o)));

   a_done_not_busy : assert property (@(posedge clk_i) disable iff (rst_i)
      done_o |-> !busy_o);

endmodule

// File: tb/tb_rom_burst_reader.sv
// Randomized bench for rom_burst_reader: a behavioural ROM plus an address/data
// expectation queue built from the burst rules, checked cycle by cycle.
module tb_rom_burst_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] start_addr;
   logic [3:0] burst_len;
   logic       busy;
   logic       done;
   logic       rom_en;
   logic [2:0] rom_addr;
   logic [7:0] rom_data = 8'h00;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] out_addr;
   logic       out_last;

   logic [7:0] mem [8];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rom_burst_reader dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .start_addr_i (start_addr),
      .burst_len_i  (burst_len),
      .busy_o       (busy),
      .done_o       (done),
      .rom_en_o     (rom_en),
      .rom_addr_o   (rom_addr),
      .rom_data_i   (rom_data),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_data_o   (out_data),
      .out_addr_o   (out_addr),
      .out_last_o   (out_last)
   );

   // One-cycle registered-read ROM.
   always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
   endtask

   // Starts a burst and checks it to completion; returns in the done cycle.
   task automatic run_burst(input logic [2:0] sa, input logic [3:0] len, input int stall_word,
                            input int stall_cycles, input bit mid_start);
      int         n;
      logic [2:0] q_addr [$];
      logic [2:0] ea;
      n = (len > 4'd8) ? 8 : int'(len);
      for (int i = 0; i < n; i++) q_addr.push_back(3'((int'(sa) + i) % 8));

      start      = 1'b1;
      start_addr = sa;
      burst_len  = len;
      out_ready  = (stall_word == 0) ? 1'b0 : 1'b1;
      tick();
      start      = 1'b0;
      start_addr = 3'($urandom);
      burst_len  = 4'($urandom);

      if (n == 0) begin
         check_eq("empty_done", done, 1);
         check_eq("empty_busy", busy, 0);
         check_eq("empty_valid", out_valid, 0);
         check_eq("empty_rom_en", rom_en, 0);
         return;
      end

      for (int w = 0; w < n; w++) begin
         ea = q_addr.pop_front();
         check_eq("req_rom_en", rom_en, 1);
         check_eq("req_rom_addr", rom_addr, ea);
         check_eq("req_busy", busy, 1);
         check_eq("req_valid", out_valid, 0);
         check_eq("req_done", done, 0);
         tick();
         check_eq("wait_rom_en", rom_en, 0);
         check_eq("wait_valid", out_valid, 0);
         tick();
         check_eq("hold_valid", out_valid, 1);
         check_eq("hold_addr", out_addr, ea);
         check_eq("hold_data", out_data, mem[ea]);
         check_eq("hold_last", out_last, (w == n - 1));
         check_eq("hold_busy", busy, 1);
         if (w == stall_word) begin
            repeat (stall_cycles) begin
               tick();
               check_eq("stall_valid", out_valid, 1);
               check_eq("stall_addr", out_addr, ea);
               check_eq("stall_data", out_data, mem[ea]);
               check_eq("stall_rom_en", rom_en, 0);
            end
         end
         if (mid_start && w == 1) begin
            start      = 1'b1;
            start_addr = 3'($urandom);
            burst_len  = 4'($urandom_range(1, 15));
         end
         out_ready = 1'b1;
         tick();
         start = 1'b0;
         check_eq("post_hs_valid", out_valid, 0);
         check_eq("post_hs_last", out_last, 0);
         out_ready = (w + 1 == stall_word) ? 1'b0 : 1'b1;
      end
      check_eq("done_pulse", done, 1);
      check_eq("done_busy", busy, 0);
      check_eq("done_rom_en", rom_en, 0);
   endtask

   initial begin
      fill_mem();
      rst        = 1'b1;
      start      = 1'b1;
      start_addr = 3'd5;
      burst_len  = 4'd8;
      out_ready  = 1'b1;
      tick();
      tick();
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_rom_en", rom_en, 0);
      check_eq("rst_rom_addr", rom_addr, 0);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_addr", out_addr, 0);
      check_eq("rst_last", out_last, 0);
      rst   = 1'b0;
      start = 1'b0;
      tick();
      check_eq("idle_busy", busy, 0);

      run_burst(3'd0, 4'd8, -1, 0, 1'b0);
      run_burst(3'd6, 4'd4, -1, 0, 1'b0);
      run_burst(3'd3, 4'd6, 2, 5, 1'b1);
      run_burst(3'd4, 4'd0, -1, 0, 1'b0);
      run_burst(3'd5, 4'd12, -1, 0, 1'b0);
      tick();
      check_eq("done_one_cycle", done, 0);

      // Reset while a word is held: it is dropped and no done follows.
      start      = 1'b1;
      start_addr = 3'd2;
      burst_len  = 4'd5;
      out_ready  = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      check_eq("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      tick();
      check_eq("mid_rst_valid", out_valid, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_done", done, 0);
      check_eq("mid_rst_rom_en", rom_en, 0);
      rst       = 1'b0;
      out_ready = 1'b1;
      tick();
      check_eq("after_rst_done", done, 0);
      tick();
      check_eq("after_rst_done2", done, 0);
      run_burst(3'd1, 4'd3, -1, 0, 1'b0);

      for (int k = 0; k < 25; k++) begin
         fill_mem();
         run_burst(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 8)), int'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)));
      end
      tick();
      check_eq("final_done", done, 0);
      check_eq("final_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
- Read-side initiator for the team's 8-entry x 8-bit synchronous ROM (3-bit address, enable, one-cycle registered read).
- On a start command it sweeps a burst of consecutive ROM addresses, wrapping from 7 to 0.
- Each word is captured and presented on a valid/ready output stream, tagged with its address and a last flag.
- Sits between the ROM and any consumer that needs sequential table reads, such as a pattern generator or serializer.

Parameters:
ADDR_W, 3, ROM address width (depth = 2**ADDR_W = 8)
DATA_W, 8, ROM data width
LEN_W, 4, width of burst_len (must hold the value 2**ADDR_W)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  burst request; sampled only in IDLE
start_addr  input  ADDR_W  first ROM address of the burst
burst_len  input  LEN_W  number of words to read (0 = empty burst; >8 clamps to 8)
busy  output  1  high while a burst is in progress
done  output  1  one-cycle pulse when a burst completes
rom_en  output  1  ROM read enable
rom_addr  output  ADDR_W  ROM address
rom_data  input  DATA_W  ROM read data, valid the cycle after rom_en
out_valid  output  1  output word valid
out_ready  input  1  consumer accepts word
out_data  output  DATA_W  captured ROM word
out_addr  output  ADDR_W  address the word was read from
out_last  output  1  final word of the burst

Behaviour:
- Reset values, applied when rst is high at a clock edge:
  - state=IDLE; busy=0; done=0; rom_en=0; rom_addr=0.
  - out_valid=0; out_data=0; out_addr=0; out_last=0; internal address and count = 0.
- rst has priority over all other inputs. Reset mid-burst abandons the burst immediately: no done pulse, and any pending word is dropped.
- States and transitions:
  - IDLE: busy=0. If start=1:
    - burst_len=0: done=1 in the next cycle, stay IDLE, no ROM access.
    - otherwise: latch cur_addr=start_addr and remaining=min(burst_len,8), then go to REQ.
  - REQ: busy=1, rom_en=1, rom_addr=cur_addr. Go to WAIT.
  - WAIT: rom_en=0. At the closing edge, register out_data<=rom_data, out_addr<=cur_addr, out_last<=(remaining==1), out_valid<=1. Go to HOLD.
  - HOLD: out_valid=1, and out_data/out_addr/out_last stay stable until out_ready=1. On handshake (out_valid & out_ready at an edge), out_valid<=0 and remaining<=remaining-1.
    - If out_last: done=1 in the next cycle, go to IDLE.
    - Otherwise: cur_addr<=cur_addr+1 modulo 8, go to REQ.
- rom_en and rom_addr are registered state outputs. rom_en is high for exactly one cycle per word; rom_addr holds its last value when rom_en=0.
- Latency and throughput:
  - start sampled at edge 0 -> REQ in cycle 1 -> out_valid first high in cycle 3.
  - With out_ready held high, a new word every 3 cycles.
  - done rises in the cycle after the last handshake and is high for exactly one cycle.
- busy is high from the cycle after start is accepted through the cycle of the last handshake. busy=0 in the cycle done=1.
- start while busy=1 is ignored with no effect. start and done in the same cycle: start is accepted, since the block is back in IDLE.
- out_ready while out_valid=0 is ignored.
- Wrap-around: the address increments modulo 8. With burst_len=8 every location is read exactly once.
- out_last is valid only when out_valid=1; it is 0 after the handshake.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 -> all outputs 0, no rom_en.
- Full burst: start_addr=0, burst_len=8, out_ready=1 -> 8 words at out_addr 0..7, out_data matching ROM model; out_valid first at cycle 3, then every 3 cycles; out_last only on addr 7; one done pulse.
- Wrap: start_addr=6, burst_len=4 -> out_addr sequence 6,7,0,1 with matching data; out_last on addr 1.
- Backpressure: out_ready=0 for 5 cycles on word 2 -> out_valid held high, out_data/out_addr unchanged, no rom_en; burst resumes after out_ready=1.
- Edge lengths: burst_len=0 -> done pulse next cycle, busy=0, no out_valid; burst_len=12 -> exactly 8 words.
- Interference: start pulsed mid-burst -> ignored; rst asserted in HOLD -> out_valid=0 next cycle, no done, new start then works normally.
